// File: rtl/hxmpp_pkg.sv
// Shared widths, the readback FSM state type and the HIM row-address helper
// used by the SSID readback path.
package hxmpp_pkg;

    localparam int SSIDBITS         = 8;
    localparam int HITINFOBITS      = 16;
    localparam int MAXHITNBITS      = 4;
    localparam int ROWINDEXBITS_HIM = 6;

    typedef enum logic [2:0] {
        IDLE,
        HNM_REQ,
        HNM_WAIT,
        HCM_REQ,
        HCM_WAIT,
        HIM_REQ,
        HIM_WAIT,
        EMPTY
    } readback_state_e;

    // HIM rows for one SSID are contiguous from the base and wrap at the top of the memory.
    function automatic logic [ROWINDEXBITS_HIM-1:0] him_row(
        input logic [ROWINDEXBITS_HIM-1:0] base,
        input logic [MAXHITNBITS-1:0]      idx
    );
        logic [ROWINDEXBITS_HIM-1:0] idx_ext;
        idx_ext = ROWINDEXBITS_HIM'(idx);
        return base + idx_ext;
    endfunction

endpackage

// File: rtl/hxmpp_readback_out_slice.sv
// Single-entry valid/ready holding register for readback output words.
// A load always wins over a same-cycle acceptance so back-to-back words do not bubble.
module readback_out_slice
    import hxmpp_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [SSIDBITS-1:0]    in_ssid,
    input  logic [HITINFOBITS-1:0] in_info,
    input  logic                   in_last,
    input  logic                   in_empty,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [SSIDBITS-1:0]    out_ssid,
    output logic [HITINFOBITS-1:0] out_info,
    output logic                   out_last,
    output logic                   out_empty
);

    logic                   valid_q, valid_d;
    logic [SSIDBITS-1:0]    ssid_q, ssid_d;
    logic [HITINFOBITS-1:0] info_q, info_d;
    logic                   last_q, last_d;
    logic                   empty_q, empty_d;

    always_comb begin
        valid_d = valid_q;
        ssid_d  = ssid_q;
        info_d  = info_q;
        last_d  = last_q;
        empty_d = empty_q;
        if (load) begin
            valid_d = 1'b1;
            ssid_d  = in_ssid;
            info_d  = in_info;
            last_d  = in_last;
            empty_d = in_empty;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ssid_q  <= '0;
            info_q  <= '0;
            last_q  <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ssid_q  <= ssid_d;
            info_q  <= info_d;
            last_q  <= last_d;
            empty_q <= empty_d;
        end
    end

    assign out_valid = valid_q;
    assign out_ssid  = ssid_q;
    assign out_info  = info_q;
    assign out_last  = last_q;
    assign out_empty = empty_q;

endmodule

// File: rtl/hxmpp_readback.sv
// Reads back all hit-info words for one SSID: HNM hit check, HCM count/base lookup,
// then one HIM read per hit, streamed through a holding register.
//
// state    | meaning
// IDLE     | waiting for a request (accepted only when the output register is empty)
// HNM_REQ  | strobe HNM lookup for ssid_q
// HNM_WAIT | waiting for HNM hit flag
// HCM_REQ  | strobe HCM row read for ssid_q
// HCM_WAIT | waiting for hit count and HIM base row
// HIM_REQ  | strobe HIM read at base+idx once the output register can take the result
// HIM_WAIT | waiting for hit info, then emit one word
// EMPTY    | emit the single "no hits" word
module hxmpp_readback
    import hxmpp_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [SSIDBITS-1:0]         req_ssid,
    output logic                        hnm_rd_en,
    output logic [SSIDBITS-1:0]         hnm_rd_ssid,
    input  logic                        hnm_rd_ready,
    input  logic                        hnm_rd_valid,
    input  logic                        hnm_rd_hit,
    output logic                        hcm_rd_en,
    output logic [SSIDBITS-1:0]         hcm_rd_row,
    input  logic                        hcm_rd_ready,
    input  logic                        hcm_rd_valid,
    input  logic [MAXHITNBITS-1:0]      hcm_rd_nhits,
    input  logic [ROWINDEXBITS_HIM-1:0] hcm_rd_addr,
    output logic                        him_rd_en,
    output logic [ROWINDEXBITS_HIM-1:0] him_rd_addr,
    input  logic                        him_rd_ready,
    input  logic                        him_rd_valid,
    input  logic [HITINFOBITS-1:0]      him_rd_info,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SSIDBITS-1:0]         out_ssid,
    output logic [HITINFOBITS-1:0]      out_info,
    output logic                        out_last,
    output logic                        out_empty,
    output logic                        busy
);

    readback_state_e             state_q, state_d;
    logic                        started_q, started_d;
    logic [SSIDBITS-1:0]         ssid_q, ssid_d;
    logic [ROWINDEXBITS_HIM-1:0] base_q, base_d;
    logic [MAXHITNBITS-1:0]      idx_q, idx_d;
    logic [MAXHITNBITS-1:0]      remaining_q, remaining_d;

    logic                        ld;
    logic [HITINFOBITS-1:0]      ld_info;
    logic                        ld_last;
    logic                        ld_empty;
    logic                        out_free;

    // The output register can take a word if it is empty or being drained this cycle.
    assign out_free = !out_valid || out_ready;

    always_comb begin
        state_d     = state_q;
        started_d   = 1'b1;
        ssid_d      = ssid_q;
        base_d      = base_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        ld          = 1'b0;
        ld_info     = '0;
        ld_last     = 1'b0;
        ld_empty    = 1'b0;
        hnm_rd_en   = 1'b0;
        hcm_rd_en   = 1'b0;
        him_rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    ssid_d  = req_ssid;
                    state_d = HNM_REQ;
                end
            end
            HNM_REQ: begin
                hnm_rd_en = hnm_rd_ready;
                if (hnm_rd_ready) state_d = HNM_WAIT;
            end
            HNM_WAIT: begin
                if (hnm_rd_valid) state_d = hnm_rd_hit ? HCM_REQ : EMPTY;
            end
            HCM_REQ: begin
                hcm_rd_en = hcm_rd_ready;
                if (hcm_rd_ready) state_d = HCM_WAIT;
            end
            HCM_WAIT: begin
                if (hcm_rd_valid) begin
                    base_d      = hcm_rd_addr;
                    remaining_d = hcm_rd_nhits;
                    idx_d       = '0;
                    state_d     = (hcm_rd_nhits == '0) ? EMPTY : HIM_REQ;
                end
            end
            HIM_REQ: begin
                if (him_rd_ready && out_free) begin
                    him_rd_en = 1'b1;
                    state_d   = HIM_WAIT;
                end
            end
            HIM_WAIT: begin
                // Issue was gated on a free output register, so the load cannot collide.
                if (him_rd_valid) begin
                    ld          = 1'b1;
                    ld_info     = him_rd_info;
                    ld_last     = (remaining_q == MAXHITNBITS'(1));
                    idx_d       = idx_q + MAXHITNBITS'(1);
                    remaining_d = remaining_q - MAXHITNBITS'(1);
                    state_d     = ld_last ? IDLE : HIM_REQ;
                end
            end
            EMPTY: begin
                if (out_free) begin
                    ld       = 1'b1;
                    ld_empty = 1'b1;
                    ld_last  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            started_q   <= 1'b0;
            ssid_q      <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            ssid_q      <= ssid_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
        end
    end

    assign req_ready   = started_q && (state_q == IDLE) && !out_valid;
    assign busy        = (state_q != IDLE);
    assign hnm_rd_ssid = ssid_q;
    assign hcm_rd_row  = ssid_q;
    assign him_rd_addr = him_row(base_q, idx_q);

    readback_out_slice u_out_slice (
        .clk       (clk),
        .reset     (reset),
        .load      (ld),
        .in_ssid   (ssid_q),
        .in_info   (ld_info),
        .in_last   (ld_last),
        .in_empty  (ld_empty),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_ssid  (out_ssid),
        .out_info  (out_info),
        .out_last  (out_last),
        .out_empty (out_empty)
    );

endmodule
